spi_engine_cmd_arbiter: RTL

//  Shares one SPI engine execution unit between two independent command masters,
//  e.g. a CPU register interface and a DMA offload.

---
 rtl/spi_engine_cmd_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spi_engine_cmd_arbiter.sv
// Two-master arbiter sharing one SPI engine execution unit, one transaction (up to SYNC) per grant.
// Optional SPI_ENGINE_ARB_FIXED_PRIO_EN: master 0 always wins a tie instead of round-robin.
module spi_engine_cmd_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  s0_cmd_valid,
    output logic                  s0_cmd_ready,
    input  logic [15:0]           s0_cmd,
    input  logic                  s0_sdo_valid,
    output logic                  s0_sdo_ready,
    input  logic [DATA_WIDTH-1:0] s0_sdo_data,
    output logic                  s0_sdi_valid,
    input  logic                  s0_sdi_ready,
    output logic [DATA_WIDTH-1:0] s0_sdi_data,
    output logic                  s0_sync_valid,
    input  logic                  s0_sync_ready,
    output logic [DATA_WIDTH-1:0] s0_sync,

    input  logic                  s1_cmd_valid,
    output logic                  s1_cmd_ready,
    input  logic [15:0]           s1_cmd,
    input  logic                  s1_sdo_valid,
    output logic                  s1_sdo_ready,
    input  logic [DATA_WIDTH-1:0] s1_sdo_data,
    output logic                  s1_sdi_valid,
    input  logic                  s1_sdi_ready,
    output logic [DATA_WIDTH-1:0] s1_sdi_data,
    output logic                  s1_sync_valid,
    input  logic                  s1_sync_ready,
    output logic [DATA_WIDTH-1:0] s1_sync,

    output logic                  m_cmd_valid,
    input  logic                  m_cmd_ready,
    output logic [15:0]           m_cmd,
    output logic                  m_sdo_valid,
    input  logic                  m_sdo_ready,
    output logic [DATA_WIDTH-1:0] m_sdo_data,
    input  logic                  m_sdi_valid,
    output logic                  m_sdi_ready,
    input  logic [DATA_WIDTH-1:0] m_sdi_data,
    input  logic                  m_sync_valid,
    output logic                  m_sync_ready,
    input  logic [DATA_WIDTH-1:0] m_sync,

    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   tie_pick_1;
    logic   sync_done;

`ifdef SPI_ENGINE_ARB_FIXED_PRIO_EN
    assign tie_pick_1 = 1'b0;
`else
    assign tie_pick_1 = ~last_owner_q;
`endif

    assign sync_done = m_sync_valid && m_sync_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            IDLE: begin
                if (s0_cmd_valid && s1_cmd_valid) begin
                    state_d = tie_pick_1 ? GRANT1 : GRANT0;
                end else if (s0_cmd_valid) begin
                    state_d = GRANT0;
                end else if (s1_cmd_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (sync_done) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end
            end
            GRANT1: begin
                if (sync_done) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data paths are muxed unconditionally; only the handshake qualifiers depend on ownership.
    assign m_cmd       = (state_q == GRANT1) ? s1_cmd      : s0_cmd;
    assign m_sdo_data  = (state_q == GRANT1) ? s1_sdo_data : s0_sdo_data;
    assign s0_sdi_data = m_sdi_data;
    assign s1_sdi_data = m_sdi_data;
    assign s0_sync     = m_sync;
    assign s1_sync     = m_sync;
    assign grant       = {state_q == GRANT1, state_q == GRANT0};

    always_comb begin
        m_cmd_valid   = 1'b0;
        m_sdo_valid   = 1'b0;
        m_sdi_ready   = 1'b0;
        m_sync_ready  = 1'b0;
        s0_cmd_ready  = 1'b0;
        s0_sdo_ready  = 1'b0;
        s0_sdi_valid  = 1'b0;
        s0_sync_valid = 1'b0;
        s1_cmd_ready  = 1'b0;
        s1_sdo_ready  = 1'b0;
        s1_sdi_valid  = 1'b0;
        s1_sync_valid = 1'b0;
        unique case (state_q)
            GRANT0: begin
                m_cmd_valid   = s0_cmd_valid;
                m_sdo_valid   = s0_sdo_valid;
                m_sdi_ready   = s0_sdi_ready;
                m_sync_ready  = s0_sync_ready;
                s0_cmd_ready  = m_cmd_ready;
                s0_sdo_ready  = m_sdo_ready;
                s0_sdi_valid  = m_sdi_valid;
                s0_sync_valid = m_sync_valid;
            end
            GRANT1: begin
                m_cmd_valid   = s1_cmd_valid;
                m_sdo_valid   = s1_sdo_valid;
                m_sdi_ready   = s1_sdi_ready;
                m_sync_ready  = s1_sync_ready;
                s1_cmd_ready  = m_cmd_ready;
                s1_sdo_ready  = m_sdo_ready;
                s1_sdi_valid  = m_sdi_valid;
                s1_sync_valid = m_sync_valid;
            end
            default: ;
        endcase
    end

endmodule
